// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM with memory wait timeouts, sticky trap and retired-instruction counter
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_wr_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rg_wr_en,
  output logic        pc_wr_en,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {
    FETCH  = 3'b000,
    DECODE = 3'b001,
    EXEC   = 3'b010,
    MEM    = 3'b011,
    WB     = 3'b100,
    TRAP   = 3'b101
  } state_t;
  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);
  state_t     cur, nxt;
  logic [1:0] cause_nxt;
  logic [7:0] wait_cnt;
  logic [6:0] op;
  logic       legal, is_mem, is_store, waiting, unused_ir;
  assign op        = instruction[6:0];
  assign unused_ir = ^instruction[31:7];
  assign is_store  = op == 7'b0100011;
  assign is_mem    = is_store || op == 7'b0000011;
  assign legal     = is_mem || op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 || op == 7'b0010111;
  assign state     = cur;
  assign trap      = cur == TRAP;
  // Requests are forced low while reset is held so nothing is pending across it
  assign imem_req  = rst_n && cur == FETCH;
  assign ir_wr_en  = imem_req && imem_ack;
  assign dmem_req  = rst_n && cur == MEM;
  assign dmem_we   = dmem_req && is_store;
  assign pc_wr_en  = rst_n && cur == WB;
  assign rg_wr_en  = pc_wr_en && !is_store;
  assign waiting   = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  always_comb begin
    nxt       = cur;
    cause_nxt = trap_cause;
    case (cur)
      FETCH:  if (imem_ack) nxt = DECODE;
              else if (wait_cnt == LIMIT) begin nxt = TRAP; cause_nxt = 2'b10; end
      DECODE: if (legal) nxt = EXEC;
              else begin nxt = TRAP; cause_nxt = 2'b01; end
      EXEC:   nxt = is_mem ? MEM : WB;
      MEM:    if (dmem_ack) nxt = WB;
              else if (wait_cnt == LIMIT) begin nxt = TRAP; cause_nxt = 2'b11; end
      WB:     nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: begin nxt = TRAP; cause_nxt = 2'b01; end
    endcase
  end
  // FETCH and MEM are only entered from non-waiting states, so the counter is 0 on entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= FETCH;
      trap_cause <= 2'b00;
      instret    <= '0;
      wait_cnt   <= '0;
    end else begin
      cur        <= nxt;
      trap_cause <= cause_nxt;
      instret    <= instret + 32'(cur == WB);
      wait_cnt   <= waiting ? wait_cnt + 8'd1 : 8'd0;
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, default 16, the number of wait cycles without acknowledge before a bus-error trap (legal range 2..255).
REQ-002 SHALL have port: clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port: instruction  in  32  current IR contents; valid from DECODE onward.
REQ-005 SHALL have port: imem_ack  in  1  instruction memory acknowledge; data is valid in the same cycle.
REQ-006 SHALL have port: dmem_ack  in  1  data memory acknowledge.
REQ-007 SHALL have port: imem_req  out  1  instruction fetch request.
REQ-008 SHALL have port: ir_wr_en  out  1  load fetched word into the IR.
REQ-009 SHALL have port: dmem_req  out  1  data memory request.
REQ-010 SHALL have port: dmem_we  out  1  data memory write (store).
REQ-011 SHALL have port: rg_wr_en  out  1  register-file write strobe.
REQ-012 SHALL have port: pc_wr_en  out  1  PC update strobe.
REQ-013 SHALL have port: state  out  3  current state encoding.
REQ-014 SHALL have port: trap  out  1  sticky fault indicator.
REQ-015 SHALL have port: trap_cause  out  2  trap reason: 00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
REQ-016 SHALL have port: instret  out  32  retired-instruction counter.

Function
REQ-017 SHALL implement states FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101; codes 110/111 SHALL go to TRAP with cause 01.
REQ-018 SHALL decode all outputs from the registered state plus the ack inputs and instruction[6:0]; there SHALL be no other combinational paths.
REQ-019 FETCH: imem_req=1; on imem_ack, ir_wr_en=1 for that cycle, then go to DECODE; otherwise remain in FETCH.
REQ-020 DECODE: one cycle; opcode 0110011, 0010011, 0000011, 0100011, 0110111 or 0010111 goes to EXEC; any other opcode goes to TRAP with cause 01.
REQ-021 EXEC: one cycle; load (0000011) or store (0100011) goes to MEM; all other legal opcodes go to WB.
REQ-022 MEM: dmem_req=1; dmem_we=1 only for store; on dmem_ack go to WB.
REQ-023 WB: one cycle; pc_wr_en=1; rg_wr_en=1 except for store; then go to FETCH.
REQ-024 instret SHALL increment by 1 on every WB cycle and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 A wait counter (8 bit) SHALL clear on entry to FETCH or MEM and increment each cycle in which the request is high and ack is low.
REQ-026 If the counter equals MEM_TIMEOUT-1 and ack is low, the next state SHALL be TRAP with cause 10 (FETCH) or 11 (MEM).
REQ-027 If ack arrives in that same cycle, ack SHALL win and no trap SHALL occur.
REQ-028 An ack received while the corresponding request is low SHALL be ignored.
REQ-029 TRAP SHALL be absorbing until reset; trap=1; all strobes and requests SHALL be 0; trap_cause SHALL hold its value.
REQ-030 Minimum latency SHALL be 4 cycles for non-memory instructions and 5 cycles for load/store, plus one cycle per ack wait.
REQ-031 rg_wr_en, pc_wr_en and ir_wr_en SHALL each be single-cycle pulses, never asserted in the same cycle as each other except rg_wr_en with pc_wr_en in WB.

Reset
REQ-032 With rst_n=0 at a clock edge, the block SHALL enter FETCH, clear instret, the wait counter and trap_cause to 0, and set trap=0.
REQ-033 During reset, every strobe and request output SHALL be 0.
REQ-034 Reset asserted in any state, including mid-wait or TRAP, SHALL take effect on that edge; no request SHALL remain pending.

Verification
REQ-035 Reset release, instruction=0x00B50533 (add), imem_ack=1 immediately -> states 000,001,010,100,000; rg_wr_en and pc_wr_en high only in WB; instret=1.
REQ-036 lw 0x0004A283, dmem_ack after 3 cycles -> MEM held 4 cycles, dmem_we=0, rg_wr_en=1 in WB; total 8 cycles.
REQ-037 sw 0x0054A023 -> dmem_we=1 in MEM; WB with rg_wr_en=0 and pc_wr_en=1.
REQ-038 Opcode 0x7F in DECODE -> TRAP, trap_cause=01; stays in TRAP for 20 cycles of imem_ack toggling.
REQ-039 imem_ack never asserted -> TRAP after exactly MEM_TIMEOUT cycles in FETCH with cause 10; ack on the final cycle instead -> DECODE.
REQ-040 rst_n pulsed low during MEM wait -> next cycle FETCH, dmem_req=0, instret=0; instret preloaded near 0xFFFFFFFF wraps to 0.
